ysyx_23060184_ifu: RTL and testbench

Instruction fetch unit for the multicycle NPC core. It owns the PC, issues one instruction-memory request at a time, and holds the returned word on a valid/ready output to decode. Decode slices the held word into `opcode`/`funct3`/`funct7`/`funct12` for the control unit. It accepts PC redirects from the downstream resolution logic (jal, jalr, taken branch, ecall, mret).

---
 rtl/ysyx_23060184_ifu_pkg.sv | 20 ++
 rtl/ysyx_23060184_pc_reg.sv | 39 +++
 rtl/ysyx_23060184_ifu.sv | 144 ++++++++++++++
 tb/tb_ysyx_23060184_ifu.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060184_ifu_pkg.sv
// Shared definitions for the NPC instruction fetch unit: FSM encodings,
// the reset NOP and the instruction field widths used by decode.
package ysyx_23060184_ifu_pkg;

  localparam int unsigned OPCODE_LENGTH  = 7;
  localparam int unsigned FUNCT3_LENGTH  = 3;
  localparam int unsigned FUNCT7_LENGTH  = 7;
  localparam int unsigned FUNCT12_LENGTH = 12;
  localparam int unsigned INST_WIDTH     = 32;
  localparam int unsigned PC_STEP        = 4;

  localparam logic [INST_WIDTH-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    IFU_ST_REQ  = 2'd0,
    IFU_ST_WAIT = 2'd1,
    IFU_ST_HOLD = 2'd2
  } ifu_state_e;

endpackage

// File: rtl/ysyx_23060184_pc_reg.sv
// Program counter: reset to RESET_PC, sequential +4 step, word-aligned redirect.
module ysyx_23060184_pc_reg
  import ysyx_23060184_ifu_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc_en,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;

  // Redirect wins over the sequential step; the low two bits are always cleared.
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc & ~XLEN'(3);
    end else if (inc_en) begin
      pc_d = pc_q + XLEN'(PC_STEP);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/ysyx_23060184_ifu.sv
// Instruction fetch unit: one outstanding imem request, held instruction on a
// valid/ready port to decode. Optional fetch counter under IFU_FETCH_CNT_EN.
module ysyx_23060184_ifu
  import ysyx_23060184_ifu_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000)
) (
`ifdef IFU_FETCH_CNT_EN
  output logic [31:0]               fetch_cnt,
`endif
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      redirect_valid,
  input  logic [XLEN-1:0]           redirect_pc,
  output logic                      imem_req_valid,
  input  logic                      imem_req_ready,
  output logic [XLEN-1:0]           imem_addr,
  input  logic                      imem_resp_valid,
  input  logic [31:0]               imem_resp_data,
  output logic                      imem_resp_ready,
  output logic                      inst_valid,
  input  logic                      inst_ready,
  output logic [31:0]               inst,
  output logic [XLEN-1:0]           inst_pc,
  output logic [OPCODE_LENGTH-1:0]  opcode,
  output logic [FUNCT3_LENGTH-1:0]  funct3,
  output logic [FUNCT7_LENGTH-1:0]  funct7,
  output logic [FUNCT12_LENGTH-1:0] funct12
);

  ifu_state_e      state_q, state_d;
  logic            drop_q, drop_d;
  logic [31:0]     inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic [XLEN-1:0] pc;
  logic            pc_inc;

  ysyx_23060184_pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk            (clk),
    .rst            (rst),
    .inc_en         (pc_inc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc             (pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IFU_ST_REQ;
      drop_q    <= 1'b0;
      inst_q    <= NOP_INST;
      inst_pc_q <= RESET_PC;
    end else begin
      state_q   <= state_d;
      drop_q    <= drop_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

  // Next state and handshake outputs; a redirect marks any in-flight fetch stale.
  always_comb begin
    state_d         = state_q;
    drop_d          = drop_q;
    inst_d          = inst_q;
    inst_pc_d       = inst_pc_q;
    pc_inc          = 1'b0;
    imem_req_valid  = 1'b0;
    imem_resp_ready = 1'b0;
    inst_valid      = 1'b0;

    unique case (state_q)
      IFU_ST_REQ: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) begin
          state_d = IFU_ST_WAIT;
          if (redirect_valid) begin
            drop_d = 1'b1;
          end
        end
      end

      IFU_ST_WAIT: begin
        imem_resp_ready = 1'b1;
        if (redirect_valid) begin
          drop_d = 1'b1;
        end
        if (imem_resp_valid) begin
          if (drop_q || redirect_valid) begin
            drop_d  = 1'b0;
            state_d = IFU_ST_REQ;
          end else begin
            inst_d    = imem_resp_data;
            inst_pc_d = pc;
            state_d   = IFU_ST_HOLD;
          end
        end
      end

      IFU_ST_HOLD: begin
        inst_valid = ~redirect_valid;
        if (redirect_valid) begin
          state_d = IFU_ST_REQ;
        end else if (inst_ready) begin
          pc_inc  = 1'b1;
          state_d = IFU_ST_REQ;
        end
      end

      default: begin
        state_d = IFU_ST_REQ;
        drop_d  = 1'b0;
      end
    endcase
  end

`ifdef IFU_FETCH_CNT_EN
  logic [31:0] fetch_cnt_q;

  // Counts instructions actually consumed by decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= 32'd0;
    end else if (inst_valid && inst_ready) begin
      fetch_cnt_q <= fetch_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
`endif

  assign imem_addr = pc;
  assign inst      = inst_q;
  assign inst_pc   = inst_pc_q;
  assign opcode    = inst_q[OPCODE_LENGTH-1:0];
  assign funct3    = inst_q[14:12];
  assign funct7    = inst_q[31:25];
  assign funct12   = inst_q[31:20];

endmodule

// File: tb/tb_ysyx_23060184_ifu.sv
// Bench for ysyx_23060184_ifu: directed vector table, reset corner cases and a
// randomized run against a transaction-level fetch model.
module tb_ysyx_23060184_ifu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_ready;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [11:0] funct12;
`ifdef IFU_FETCH_CNT_EN
  logic [31:0] fetch_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  ysyx_23060184_ifu dut (
`ifdef IFU_FETCH_CNT_EN
    .fetch_cnt       (fetch_cnt),
`endif
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .imem_resp_ready (imem_resp_ready),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .opcode          (opcode),
    .funct3          (funct3),
    .funct7          (funct7),
    .funct12         (funct12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish before time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory contents: an arbitrary but deterministic word per address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        ir;
    logic        qr;
    logic        sv;
    logic [31:0] sd;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_rsp;
    logic        e_iv;
    logic [31:0] e_ipc;
    logic [31:0] e_inst;
  } vec_t;

  function automatic vec_t v(input logic rv, input logic [31:0] rpc, input logic ir,
                             input logic qr, input logic sv, input logic [31:0] sd,
                             input logic e_req, input logic [31:0] e_addr, input logic e_rsp,
                             input logic e_iv, input logic [31:0] e_ipc, input logic [31:0] e_inst);
    vec_t r;
    r.rv = rv; r.rpc = rpc; r.ir = ir; r.qr = qr; r.sv = sv; r.sd = sd;
    r.e_req = e_req; r.e_addr = e_addr; r.e_rsp = e_rsp;
    r.e_iv = e_iv; r.e_ipc = e_ipc; r.e_inst = e_inst;
    return r;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    inst_ready      = 1'b0;
  endtask

  // Randomized-run model state: transaction level (pc, one in-flight fetch, held word).
  logic [31:0] model_pc, out_addr, held_pc, req_addr;
  logic        outstanding, live, held;
  logic        req_hs, resp_hs, inst_hs;
  int          mem_cnt, n_deliv, idle_cnt;

  localparam logic [31:0] W0 = 32'h0000_0093;
  localparam logic [31:0] W1 = 32'h0010_0113;
  localparam logic [31:0] W2 = 32'hDEAD_BEEF;
  localparam logic [31:0] W3 = 32'h0020_8193;
  localparam logic [31:0] W4 = 32'h0030_0213;
  localparam logic [31:0] W5 = 32'h0040_0293;
  localparam logic [31:0] W6 = 32'hCAFE_F00D;

  vec_t tbl[28];

  initial begin
    // Directed sequence, one record per clock cycle after reset release.
    tbl[0]  = v(0, 0,            0, 1, 0, 0,  1, RST_PC,        0, 0, 0, 0);
    tbl[1]  = v(0, 0,            0, 0, 1, W0, 0, 0,             1, 0, 0, 0);
    tbl[2]  = v(0, 0,            1, 0, 0, 0,  0, 0,             0, 1, RST_PC, W0);
    tbl[3]  = v(0, 0,            0, 0, 0, 0,  1, RST_PC + 4,    0, 0, 0, 0);
    tbl[4]  = v(0, 0,            0, 1, 0, 0,  1, RST_PC + 4,    0, 0, 0, 0);
    tbl[5]  = v(0, 0,            0, 0, 1, W1, 0, 0,             1, 0, 0, 0);
    for (int i = 6; i <= 10; i++)
      tbl[i] = v(0, 0,           0, 0, 0, 0,  0, 0,             0, 1, RST_PC + 4, W1);
    tbl[11] = v(0, 0,            1, 0, 0, 0,  0, 0,             0, 1, RST_PC + 4, W1);
    tbl[12] = v(0, 0,            0, 1, 0, 0,  1, RST_PC + 8,    0, 0, 0, 0);
    tbl[13] = v(1, 32'h8000_0102, 0, 0, 0, 0, 0, 0,             1, 0, 0, 0);
    tbl[14] = v(0, 0,            0, 0, 1, W2, 0, 0,             1, 0, 0, 0);
    tbl[15] = v(0, 0,            0, 1, 0, 0,  1, 32'h8000_0100, 0, 0, 0, 0);
    tbl[16] = v(0, 0,            0, 0, 1, W3, 0, 0,             1, 0, 0, 0);
    tbl[17] = v(1, 32'h8000_0200, 1, 0, 0, 0, 0, 0,             0, 0, 0, 0);
    tbl[18] = v(0, 0,            0, 1, 0, 0,  1, 32'h8000_0200, 0, 0, 0, 0);
    tbl[19] = v(0, 0,            0, 0, 1, W4, 0, 0,             1, 0, 0, 0);
    tbl[20] = v(1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0);
    tbl[21] = v(0, 0,            0, 1, 0, 0,  1, 32'hFFFF_FFFC, 0, 0, 0, 0);
    tbl[22] = v(0, 0,            0, 0, 1, W5, 0, 0,             1, 0, 0, 0);
    tbl[23] = v(0, 0,            1, 0, 0, 0,  0, 0,             0, 1, 32'hFFFF_FFFC, W5);
    tbl[24] = v(0, 0,            0, 0, 0, 0,  1, 32'h0000_0000, 0, 0, 0, 0);
    tbl[25] = v(1, 32'h8000_0300, 0, 1, 0, 0, 1, 32'h0000_0000, 0, 0, 0, 0);
    tbl[26] = v(0, 0,            0, 0, 1, W6, 0, 0,             1, 0, 0, 0);
    tbl[27] = v(0, 0,            0, 0, 0, 0,  1, 32'h8000_0300, 0, 0, 0, 0);

    idle_inputs();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 1);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_resp_ready", 32'(imem_resp_ready), 0);
    chk("rst_inst_valid", 32'(inst_valid), 0);
    chk("rst_inst", inst, NOP);
    chk("rst_inst_pc", inst_pc, RST_PC);
    chk("rst_opcode", 32'(opcode), 32'h13);
`ifdef IFU_FETCH_CNT_EN
    chk("rst_fetch_cnt", fetch_cnt, 0);
`endif

    for (int i = 0; i < 28; i++) begin
      redirect_valid  = tbl[i].rv;
      redirect_pc     = tbl[i].rpc;
      inst_ready      = tbl[i].ir;
      imem_req_ready  = tbl[i].qr;
      imem_resp_valid = tbl[i].sv;
      imem_resp_data  = tbl[i].sd;
      #1;
      chk($sformatf("vec%0d_req_valid", i), 32'(imem_req_valid), 32'(tbl[i].e_req));
      if (tbl[i].e_req) chk($sformatf("vec%0d_addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("vec%0d_resp_ready", i), 32'(imem_resp_ready), 32'(tbl[i].e_rsp));
      chk($sformatf("vec%0d_inst_valid", i), 32'(inst_valid), 32'(tbl[i].e_iv));
      if (tbl[i].e_iv) begin
        chk($sformatf("vec%0d_inst", i), inst, tbl[i].e_inst);
        chk($sformatf("vec%0d_inst_pc", i), inst_pc, tbl[i].e_ipc);
        chk($sformatf("vec%0d_opcode", i), 32'(opcode), 32'(tbl[i].e_inst & 32'h7F));
      end
      cycle();
    end
    idle_inputs();
`ifdef IFU_FETCH_CNT_EN
    chk("vec_fetch_cnt", fetch_cnt, 3);
`endif

    // Reset while a fetch is in WAIT: request abandoned, back to REQ at RESET_PC.
    imem_req_ready = 1'b1;
    #1;
    cycle();
    imem_req_ready = 1'b0;
    #1;
    chk("midwait_in_wait", 32'(imem_resp_ready), 1);
    rst = 1'b1;
    #1;
    chk("midwait_rst_req_valid", 32'(imem_req_valid), 1);
    chk("midwait_rst_addr", imem_addr, RST_PC);
    chk("midwait_rst_inst_valid", 32'(inst_valid), 0);
    chk("midwait_rst_resp_ready", 32'(imem_resp_ready), 0);
    cycle();
    rst = 1'b0;
    cycle();
    chk("midwait_post_req_valid", 32'(imem_req_valid), 1);
    chk("midwait_post_addr", imem_addr, RST_PC);
    chk("midwait_post_inst_valid", 32'(inst_valid), 0);

    // Randomized run against the transaction-level model.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    model_pc = RST_PC; out_addr = 0; held_pc = 0;
    outstanding = 0; live = 0; held = 0;
    mem_cnt = 0; n_deliv = 0; idle_cnt = 0;

    for (int c = 0; c < 3000; c++) begin
      inst_ready     = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0)
        redirect_pc = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
      else
        redirect_pc = 32'h8000_0000 | ($urandom & 32'h0000_FFFF);
      imem_req_ready  = ($urandom_range(0, 9) < 7);
      imem_resp_valid = outstanding && (mem_cnt == 0);
      imem_resp_data  = imem_resp_valid ? mem_word(out_addr) : $urandom;
      #1;

      chk("rnd_inst_valid", 32'(inst_valid), 32'(held && !redirect_valid));
      if (held) begin
        chk("rnd_inst", inst, mem_word(held_pc));
        chk("rnd_inst_pc", inst_pc, held_pc);
        chk("rnd_opcode", 32'(opcode), mem_word(held_pc) & 32'h7F);
        chk("rnd_funct3", 32'(funct3), (mem_word(held_pc) >> 12) & 32'h7);
        chk("rnd_funct7", 32'(funct7), mem_word(held_pc) >> 25);
        chk("rnd_funct12", 32'(funct12), mem_word(held_pc) >> 20);
      end
      if (imem_req_valid) begin
        chk("rnd_addr", imem_addr, model_pc);
        chk("rnd_single_outstanding", 32'(outstanding || held), 0);
      end
`ifdef IFU_FETCH_CNT_EN
      chk("rnd_fetch_cnt", fetch_cnt, 32'(n_deliv));
`endif

      req_hs   = imem_req_valid && imem_req_ready;
      resp_hs  = imem_resp_valid && imem_resp_ready;
      inst_hs  = inst_valid && inst_ready;
      req_addr = imem_addr;

      if (resp_hs) begin
        outstanding = 1'b0;
        if (live && !redirect_valid) begin
          held    = 1'b1;
          held_pc = out_addr;
        end
      end else if (outstanding && mem_cnt > 0) begin
        mem_cnt--;
      end
      if (req_hs) begin
        outstanding = 1'b1;
        out_addr    = req_addr;
        live        = !redirect_valid;
        mem_cnt     = $urandom_range(0, 2);
      end
      if (inst_hs) begin
        held     = 1'b0;
        model_pc = held_pc + 32'd4;
        n_deliv++;
      end
      if (redirect_valid) begin
        model_pc = redirect_pc & ~32'd3;
        live     = 1'b0;
        held     = 1'b0;
      end

      if (req_hs || resp_hs || inst_hs || redirect_valid) idle_cnt = 0;
      else idle_cnt++;
      if (idle_cnt > 40) begin
        n_checks++;
        n_fail++;
        $display("FAIL rnd_progress: got %0d idle cycles expected at most 40 at %0t", idle_cnt, $time);
        break;
      end
      cycle();
    end

    idle_inputs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
